serdesphy_rx_aligner: RTL and testbench
=======================================

// Module: serdesphy_rx_aligner
// PURPOSE
//  RX frame aligner. Consumes the recovered 1-bit stream from the deserializer interface
//  (rx_serial_data/valid/error), finds SYNC_WORD frame markers, and locks after
//  LOCK_COUNT consecutive good markers. While locked it emits payload nibbles as rx_data/rx_valid
//  into the RX FIFO, and reports alignment status (rx_aligned) to the CSR block.
// PARAMETERS
//  SYNC_WORD      8'hD5  frame marker, compared MSB-first (first received bit = bit 7)
//  FRAME_NIBBLES  16     payload nibbles per frame (range 1..64)
//  LOCK_COUNT     3      consecutive good markers to reach LOCKED (1..15, counts first detect)
//  LOSS_COUNT     2      consecutive missed markers in LOCKED to drop to HUNT (1..15)
// PORTS
//  clk              in   1  240 MHz RX clock (CDR domain)
//  rst              in   1  synchronous active-high reset
//  rx_align_rst     in   1  sync soft reset of FSM/counters/sticky flags (CSR, pre-synchronised)
//  rx_serial_data   in   1  received bit
//  rx_serial_valid  in   1  bit qualifier; bit consumed only on cycles where high
//  rx_serial_error  in   1  deserializer error, sampled only with rx_serial_valid
//  rx_data          out  4  payload nibble, first received bit in rx_data[3]
//  rx_valid         out  1  one-cycle strobe, rx_data valid
//  rx_aligned       out  1  high in LOCKED only
//  align_state      out  2  00 HUNT, 01 VERIFY, 10 LOCKED
//  sync_miss_cnt    out  8  saturating count of missed markers (VERIFY+LOCKED)
//  rx_bit_err       out  1  sticky: rx_serial_error seen while LOCKED
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. Port names clk, rst.
//  Reset (rst or rx_align_rst): state HUNT, shift reg 0, pos 0, good/miss counters 0;
//   all outputs 0. rst has priority over rx_align_rst, and both override any bit that cycle.
//  Only cycles with rx_serial_valid=1 advance anything. sr <= {sr[6:0],rx_serial_data}.
//   "sr_next" below means the post-shift value.
//  Frame length F = 8 + 4*FRAME_NIBBLES bits. pos counts 0..F-1 after each marker.
//   pos=0 is the first payload bit. pos=F-1 is the last marker bit.
//   At pos=F-1, check sr_next==SYNC_WORD, then pos wraps to 0.
//  HUNT: every valid bit, if sr_next==SYNC_WORD -> VERIFY, pos<=0, good<=1.
//   If LOCK_COUNT==1, go directly to LOCKED. No data is output in HUNT.
//  VERIFY: at pos=F-1, marker good -> good+1; when good reaches LOCK_COUNT -> LOCKED.
//   Marker bad -> HUNT, sync_miss_cnt+1. No re-search is made on that same bit.
//   No data is output in VERIFY.
//  LOCKED: payload at pos 0..4*FRAME_NIBBLES-1. When a nibble's 4th bit is accepted,
//   rx_data/rx_valid are registered, so rx_valid=1 for exactly the next cycle (latency 1 clk).
//   Marker check at pos=F-1: good -> miss<=0.
//   Bad -> miss+1, sync_miss_cnt+1 (saturates at 8'hFF).
//   Bad with miss+1==LOSS_COUNT -> HUNT, and rx_aligned drops at that same edge.
//   Otherwise stay LOCKED (flywheel): the frame timing holds and the next frame's
//   payload is still output.
//  rx_serial_error with valid while LOCKED sets rx_bit_err. It is cleared only by rst/rx_align_rst.
//  The FIFO has no back-pressure; downstream must accept every rx_valid strobe.
//  The state encoding value 11 is illegal; if it is reached, go to HUNT on the next clock.
//  Gaps in rx_serial_valid of any length are legal and freeze all state.
// TESTING
//  1 Reset: rst=1 for 2 clks, stream random bits -> all outputs 0, align_state=00.
//  2 Lock: defaults, 3 frames of D5 + 64 payload bits -> rx_aligned rises on the 3rd marker's last bit.
//    4th frame payload 0x0..0xF -> 16 rx_valid strobes, rx_data 0,1,..,F, each 1 clk after its 4th bit.
//  3 Flywheel/loss: locked, corrupt one marker (0xD4) -> still locked, sync_miss_cnt=1, payload still output.
//    Corrupt two consecutive markers -> align_state=00 on the 2nd bad marker's last bit, sync_miss_cnt=3.
//  4 Verify fail: good marker, then bad marker at the next boundary -> HUNT, no rx_valid ever asserted.
//  5 Valid gaps: insert random rx_serial_valid=0 cycles (up to 50%) during test 2 -> identical nibble sequence.
//  6 Soft reset mid-frame: rx_align_rst pulsed while LOCKED with rx_bit_err=1 -> state 00 next clk,
//    rx_bit_err=0, sync_miss_cnt=0, then relock after 3 markers.

Source files
------------

// File: rtl/serdesphy_rx_aligner.sv
// RX frame aligner: hunts for the sync marker in the recovered bit stream,
// verifies and locks on consecutive markers, then emits payload nibbles.
module serdesphy_rx_aligner #(
    parameter logic [7:0]  SYNC_WORD     = 8'hD5,
    parameter int unsigned FRAME_NIBBLES = 16,
    parameter int unsigned LOCK_COUNT    = 3,
    parameter int unsigned LOSS_COUNT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_align_rst,
    input  logic       rx_serial_data,
    input  logic       rx_serial_valid,
    input  logic       rx_serial_error,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       rx_aligned,
    output logic [1:0] align_state,
    output logic [7:0] sync_miss_cnt,
    output logic       rx_bit_err
);

    localparam int unsigned PAYLOAD_BITS = 4 * FRAME_NIBBLES;
    localparam int unsigned FRAME_BITS   = 8 + PAYLOAD_BITS;
    localparam int unsigned POS_W        = $clog2(FRAME_BITS);
    localparam int unsigned CNT_W        = 4;

    localparam logic [1:0] ST_HUNT    = 2'b00;
    localparam logic [1:0] ST_VERIFY  = 2'b01;
    localparam logic [1:0] ST_LOCKED  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(FRAME_BITS - 1);
    localparam logic [POS_W-1:0] POS_PAY_END = POS_W'(PAYLOAD_BITS);
    localparam logic [CNT_W-1:0] LOCK_TGT    = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] LOSS_TGT    = CNT_W'(LOSS_COUNT);

    // State and datapath registers
    logic [1:0]       r_state;
    logic [6:0]       r_sr;          // last 7 accepted bits; the 8th comes from the input
    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] r_miss;
    logic [3:0]       r_data;
    logic             r_valid;
    logic             r_aligned;
    logic [7:0]       r_miss_cnt;
    logic             r_bit_err;

    // Next-state values
    logic [1:0]       w_state_nxt;
    logic [6:0]       w_sr_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    logic [CNT_W-1:0] w_good_nxt;
    logic [CNT_W-1:0] w_miss_nxt;
    logic [3:0]       w_data_nxt;
    logic             w_valid_nxt;
    logic [7:0]       w_miss_cnt_nxt;
    logic             w_bit_err_nxt;

    // Helper terms
    logic [7:0]       w_sr_shift;
    logic             w_marker_ok;
    logic             w_at_last;
    logic [POS_W-1:0] w_pos_inc;
    logic             w_nib_end;
    logic [CNT_W-1:0] w_good_inc;
    logic [CNT_W-1:0] w_miss_inc;
    logic [7:0]       w_miss_cnt_sat;

    // Shift-register lookahead, frame position and counter increments
    assign w_sr_shift     = {r_sr, rx_serial_data};
    assign w_marker_ok    = (w_sr_shift == SYNC_WORD);
    assign w_at_last      = (r_pos == POS_LAST);
    assign w_pos_inc      = w_at_last ? '0 : r_pos + POS_W'(1);
    assign w_nib_end      = (r_pos < POS_PAY_END) && (r_pos[1:0] == 2'b11);
    assign w_good_inc     = r_good + CNT_W'(1);
    assign w_miss_inc     = r_miss + CNT_W'(1);
    assign w_miss_cnt_sat = (r_miss_cnt == 8'hFF) ? 8'hFF : r_miss_cnt + 8'd1;

    // Next-state logic for the HUNT/VERIFY/LOCKED machine and its counters
    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_pos_nxt      = r_pos;
        w_good_nxt     = r_good;
        w_miss_nxt     = r_miss;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_miss_cnt_nxt = r_miss_cnt;
        w_bit_err_nxt  = r_bit_err;

        if (r_state == ST_ILLEGAL) begin
            // Recover from an unreachable encoding without waiting for a bit
            w_state_nxt = ST_HUNT;
            w_pos_nxt   = '0;
            w_good_nxt  = '0;
            w_miss_nxt  = '0;
        end else if (rx_serial_valid) begin
            w_sr_nxt = w_sr_shift[6:0];
            case (r_state)
                ST_HUNT: begin
                    if (w_marker_ok) begin
                        w_pos_nxt   = '0;
                        w_good_nxt  = CNT_W'(1);
                        w_miss_nxt  = '0;
                        w_state_nxt = (LOCK_TGT == CNT_W'(1)) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    w_pos_nxt = w_pos_inc;
                    if (w_at_last) begin
                        if (w_marker_ok) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == LOCK_TGT) begin
                                w_state_nxt = ST_LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            // Bad marker: drop back; the search restarts on the next bit
                            w_state_nxt    = ST_HUNT;
                            w_good_nxt     = '0;
                            w_miss_cnt_nxt = w_miss_cnt_sat;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_pos_nxt = w_pos_inc;
                    if (rx_serial_error) begin
                        w_bit_err_nxt = 1'b1;
                    end
                    if (w_nib_end) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_sr_shift[3:0];
                    end
                    if (w_at_last) begin
                        if (w_marker_ok) begin
                            w_miss_nxt = '0;
                        end else begin
                            // Flywheel through isolated misses; lose lock after LOSS_COUNT
                            w_miss_nxt     = w_miss_inc;
                            w_miss_cnt_nxt = w_miss_cnt_sat;
                            if (w_miss_inc == LOSS_TGT) begin
                                w_state_nxt = ST_HUNT;
                                w_miss_nxt  = '0;
                                w_good_nxt  = '0;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // State, counters and registered outputs; both resets clear everything
    always_ff @(posedge clk) begin
        if (rst || rx_align_rst) begin
            r_state    <= ST_HUNT;
            r_sr       <= '0;
            r_pos      <= '0;
            r_good     <= '0;
            r_miss     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_aligned  <= 1'b0;
            r_miss_cnt <= '0;
            r_bit_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_pos      <= w_pos_nxt;
            r_good     <= w_good_nxt;
            r_miss     <= w_miss_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_aligned  <= (w_state_nxt == ST_LOCKED);
            r_miss_cnt <= w_miss_cnt_nxt;
            r_bit_err  <= w_bit_err_nxt;
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_aligned    = r_aligned;
    assign align_state   = r_state;
    assign sync_miss_cnt = r_miss_cnt;
    assign rx_bit_err    = r_bit_err;

endmodule

// File: tb/tb_serdesphy_rx_aligner.sv
// Scoreboard bench for serdesphy_rx_aligner: stimulus queues expected nibbles
// with their due cycle, a monitor pops and compares on every rx_valid strobe.
module tb_serdesphy_rx_aligner;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_align_rst;
    logic       rx_serial_data;
    logic       rx_serial_valid;
    logic       rx_serial_error;
    logic [3:0] rx_data;
    logic       rx_valid;
    logic       rx_aligned;
    logic [1:0] align_state;
    logic [7:0] sync_miss_cnt;
    logic       rx_bit_err;

    always #5 clk = ~clk;

    serdesphy_rx_aligner dut (
        .clk             (clk),
        .rst             (rst),
        .rx_align_rst    (rx_align_rst),
        .rx_serial_data  (rx_serial_data),
        .rx_serial_valid (rx_serial_valid),
        .rx_serial_error (rx_serial_error),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_aligned      (rx_aligned),
        .align_state     (align_state),
        .sync_miss_cnt   (sync_miss_cnt),
        .rx_bit_err      (rx_bit_err)
    );

    typedef struct {
        logic [3:0]  nib;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks  = 0;
    int          n_fail    = 0;
    int unsigned cyc       = 0;
    int unsigned valid_cnt = 0;
    int unsigned gap_pct   = 0;

    localparam logic [63:0] PL_ZERO = 64'h0;
    localparam logic [63:0] PL_INC  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PL_DEC  = 64'hFEDC_BA98_7654_3210;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expectation, on its due cycle
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            valid_cnt++;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got rx_data=%h at cycle %0d, required no strobe", rx_data, cyc);
            end else begin
                mon_e = q.pop_front();
                if (rx_data !== mon_e.nib || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL nibble: got %h at cycle %0d, required %h at cycle %0d",
                             rx_data, cyc, mon_e.nib, mon_e.cyc);
                end
            end
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            mon_e = q.pop_front();
            $display("FAIL missing_strobe: no rx_valid at cycle %0d, required nibble %h", mon_e.cyc, mon_e.nib);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input logic al,
                                input logic [7:0] cnt, input logic be);
        check({tag, ".align_state"}, 32'(align_state), 32'(st));
        check({tag, ".rx_aligned"}, 32'(rx_aligned), 32'(al));
        check({tag, ".sync_miss_cnt"}, 32'(sync_miss_cnt), 32'(cnt));
        check({tag, ".rx_bit_err"}, 32'(rx_bit_err), 32'(be));
    endtask

    task automatic drive(input logic r, input logic a, input logic d, input logic v, input logic e);
        @(negedge clk);
        rst             = r;
        rx_align_rst    = a;
        rx_serial_data  = d;
        rx_serial_valid = v;
        rx_serial_error = e;
    endtask

    // One accepted bit, optionally preceded by random idle gaps; ends 1 ns after its edge
    task automatic send_bit(input logic b, input logic e, input logic push, input logic [3:0] nib);
        exp_t x;
        while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
            drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
        end
        drive(1'b0, 1'b0, b, 1'b1, e);
        if (push) begin
            x.nib = nib;
            x.cyc = cyc + 1;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, 1'b0, 4'h0);
    endtask

    task automatic send_payload(input logic [63:0] pl, input logic exp_out, input int err_bit);
        for (int i = 0; i < 64; i++) begin
            send_bit(pl[63-i], 1'(i == err_bit), 1'(exp_out && (i % 4 == 3)),
                     pl[63 - 4*(i/4) -: 4]);
        end
    endtask

    task automatic pulse_align_rst();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic lock_sequence(input string tag);
        send_byte(8'hD5);
        check_status({tag, ".m1"}, 2'b01, 1'b0, 8'd0, 1'b0);
        send_payload(PL_ZERO, 1'b0, -1);
        send_byte(8'hD5);
        check_status({tag, ".m2"}, 2'b01, 1'b0, 8'd0, 1'b0);
        send_payload(PL_ZERO, 1'b0, -1);
        send_byte(8'hD5);
        check_status({tag, ".m3"}, 2'b10, 1'b1, 8'd0, 1'b0);
        send_payload(PL_INC, 1'b1, -1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v0;
        rst = 1'b1; rx_align_rst = 1'b0; rx_serial_data = 1'b0;
        rx_serial_valid = 1'b0; rx_serial_error = 1'b0;

        // Reset held for two clocks with random bits streaming in
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)));
            @(posedge clk);
            #1;
            check_status("reset", 2'b00, 1'b0, 8'd0, 1'b0);
            check("reset.rx_valid", 32'(rx_valid), 32'd0);
            check("reset.rx_data", 32'(rx_data), 32'd0);
        end

        // Lock on three markers, then the 4th frame's payload 0..F
        lock_sequence("lock");

        // Flywheel: a single bad marker keeps lock and payload flowing
        send_byte(8'hD4);
        check_status("fly1", 2'b10, 1'b1, 8'd1, 1'b0);
        send_payload(PL_DEC, 1'b1, -1);
        send_byte(8'hD5);
        check_status("fly_good", 2'b10, 1'b1, 8'd1, 1'b0);
        send_payload(PL_INC, 1'b1, -1);
        send_byte(8'hD4);
        check_status("loss1", 2'b10, 1'b1, 8'd2, 1'b0);
        send_payload(PL_DEC, 1'b1, -1);
        send_byte(8'hD4);
        check_status("loss2", 2'b00, 1'b0, 8'd3, 1'b0);
        send_payload(PL_ZERO, 1'b0, -1);
        check_status("loss_hunt", 2'b00, 1'b0, 8'd3, 1'b0);

        // Verify failure: error bit in VERIFY does not set the sticky flag
        pulse_align_rst();
        check_status("vfail_rst", 2'b00, 1'b0, 8'd0, 1'b0);
        v0 = valid_cnt;
        send_byte(8'hD5);
        check_status("vfail_m1", 2'b01, 1'b0, 8'd0, 1'b0);
        send_payload(PL_INC, 1'b0, 10);
        send_byte(8'hD4);
        check_status("vfail_m2", 2'b00, 1'b0, 8'd1, 1'b0);
        check("vfail.no_strobes", valid_cnt, v0);

        // Same lock sequence with random valid gaps
        pulse_align_rst();
        check_status("gaps_rst", 2'b00, 1'b0, 8'd0, 1'b0);
        gap_pct = 50;
        lock_sequence("gaps");
        gap_pct = 0;

        // Sticky bit error while locked, then soft reset mid-frame and relock
        send_byte(8'hD4);
        check_status("soft_fly", 2'b10, 1'b1, 8'd1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 4'h0);
        send_bit(1'b0, 1'b1, 1'b0, 4'h0);
        send_bit(1'b0, 1'b0, 1'b0, 4'h0);
        send_bit(1'b1, 1'b0, 1'b1, 4'h9);
        check_status("soft_err", 2'b10, 1'b1, 8'd1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0, 4'h0);
        send_bit(1'b0, 1'b0, 1'b0, 4'h0);
        pulse_align_rst();
        check_status("soft_rst", 2'b00, 1'b0, 8'd0, 1'b0);
        check("soft_rst.rx_valid", 32'(rx_valid), 32'd0);
        lock_sequence("relock");
        send_byte(8'hD5);
        check_status("relock_m4", 2'b10, 1'b1, 8'd0, 1'b0);

        // Drain and confirm every expected nibble was seen
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
